conv11_mac_requant: RTL and testbench

Parametrised 1x1 (pointwise) convolution engine for the conv11 path. For each output pixel it accumulates `LANES` signed 8-bit data×weight products per beat over any number of beats (input channels). It then adds the per-output-channel bias, requantises with a fixed-point scale and a rounding shift, and applies optional ReLU and saturation. The result is emitted through a valid/ready handshake. It replaces the single-product conv11 calculator, which had no channel accumulation, no rounding and no backpressure.

---
 rtl/conv11_mac_requant.sv | 119 +++++++++++
 tb/tb_conv11_mac_requant.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/conv11_mac_requant.sv
// conv11_mac_requant: pointwise conv MAC over LANES-wide beats with bias, fixed-point requantisation,
// optional ReLU and saturation, emitted through a valid/ready handshake.
module conv11_mac_requant #(
    parameter int DATA_WIDTH = 8,
    parameter int MUL_WIDTH  = 16,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int BIAS_WIDTH = 32,
    parameter int SHIFT      = 16,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_last,
    input  logic        [LANES*DATA_WIDTH-1:0]  data_in,
    input  logic        [LANES*DATA_WIDTH-1:0]  weight_in,
    input  logic signed [BIAS_WIDTH-1:0]        bias,
    input  logic signed [BIAS_WIDTH-1:0]        scale,
    input  logic                                relu_en,
    output logic signed [OUT_WIDTH-1:0]         result,
    output logic                                out_valid,
    input  logic                                out_ready
);
    localparam int TW = ACC_WIDTH + 1;
    localparam int PW = TW + BIAS_WIDTH;
    localparam logic signed [PW-1:0] HALF = PW'(1) << (SHIFT - 1);
    localparam logic signed [PW-1:0] MAXV = PW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    typedef enum logic [2:0] {ACC, BIAS, SCALE, ROUND, OUT} state_t;

    state_t                       r_state, w_next;
    logic signed [ACC_WIDTH-1:0]  r_acc, r_sum, w_beat_sum, w_acc_next;
    logic signed [BIAS_WIDTH-1:0] r_bias, r_scale;
    logic                         r_relu, r_out_valid, w_fire;
    logic signed [TW-1:0]         r_t;
    logic signed [PW-1:0]         r_p, w_round, w_relu;
    logic signed [OUT_WIDTH-1:0]  r_result, w_sat;
    logic signed [MUL_WIDTH-1:0]  w_prod [LANES];

    genvar l;
    for (l = 0; l < LANES; l++) begin : g_lane
        logic signed [MUL_WIDTH-1:0] w_d, w_w;
        assign w_d = MUL_WIDTH'($signed(data_in[l*DATA_WIDTH +: DATA_WIDTH]));
        assign w_w = MUL_WIDTH'($signed(weight_in[l*DATA_WIDTH +: DATA_WIDTH]));
        assign w_prod[l] = w_d * w_w;
    end

    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < LANES; i++)
            w_beat_sum = w_beat_sum + ACC_WIDTH'(w_prod[i]);
    end

    assign w_acc_next = r_acc + w_beat_sum;
    assign w_fire     = in_valid && in_ready;
    // Arithmetic shift of the biased product gives round-half-toward-+inf.
    assign w_round    = (r_p + HALF) >>> SHIFT;
    assign w_relu     = (r_relu && w_round < 0) ? '0 : w_round;
    assign w_sat      = w_relu > MAXV ? OUT_WIDTH'(MAXV) :
                        w_relu < MINV ? OUT_WIDTH'(MINV) : OUT_WIDTH'(w_relu);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACC;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        case (r_state)
            ACC: begin
                in_ready = 1'b1;
                w_next   = (in_valid && in_last) ? BIAS : ACC;
            end
            BIAS:    w_next = SCALE;
            SCALE:   w_next = ROUND;
            ROUND:   w_next = OUT;
            OUT:     w_next = out_ready ? ACC : OUT;
            default: w_next = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_sum       <= '0;
            r_bias      <= '0;
            r_scale     <= '0;
            r_relu      <= 1'b0;
            r_t         <= '0;
            r_p         <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_fire) begin
                r_acc <= in_last ? '0 : w_acc_next;
                if (in_last) begin
                    r_sum   <= w_acc_next;
                    r_bias  <= bias;
                    r_scale <= scale;
                    r_relu  <= relu_en;
                end
            end
            if (r_state == BIAS)  r_t <= TW'(r_sum) + TW'(r_bias);
            if (r_state == SCALE) r_p <= PW'(r_t) * PW'(r_scale);
            if (r_state == ROUND) begin
                r_result    <= w_sat;
                r_out_valid <= 1'b1;
            end
            if (r_state == OUT && out_ready) r_out_valid <= 1'b0;
        end
    end

    assign result    = r_result;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_conv11_mac_requant.sv
// tb_conv11_mac_requant: directed vectors with a queue-based scoreboard for conv11_mac_requant.
module tb_conv11_mac_requant;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_last = 1'b0;
    logic [31:0]        data_in = '0;
    logic [31:0]        weight_in = '0;
    logic signed [31:0] bias = '0;
    logic signed [31:0] scale = '0;
    logic               relu_en = 1'b0;
    logic signed [7:0]  result;
    logic               out_valid;
    logic               out_ready = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int q[$];

    conv11_mac_requant dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .data_in(data_in), .weight_in(weight_in), .bias(bias), .scale(scale),
        .relu_en(relu_en), .result(result), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Monitor: every handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_output", int'(result), 9999);
            else chk("result", int'(result), q.pop_front());
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic beat(input logic [31:0] d, input logic [31:0] w, input logic last,
                        input int b, input int s, input logic r);
        logic rdy;
        int k = 0;
        in_valid = 1'b1; in_last = last; data_in = d; weight_in = w;
        bias = b; scale = s; relu_en = r;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!rdy && k < 200);
        if (!rdy) chk("beat_accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pixel(input int n, input logic [31:0] d, input logic [31:0] w,
                         input int b, input int s, input logic r, input int exp);
        q.push_back(exp);
        for (int k = 0; k < n; k++) beat(d, w, k == n - 1, b, s, r);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #12;
        chk("reset_result", int'(result), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);

        // single beat with latency check: valid appears after the third edge following acceptance
        pixel(1, pk(1, 2, 3, 4), pk(1, 1, 1, 1), 0, 65536, 1'b0, 10);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("latency_not_yet", int'(out_valid), 0);
        end
        @(negedge clk);
        chk("latency_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;

        pixel(3, pk(10, 10, 10, 10), pk(10, 10, 10, 10), -200, 32768, 1'b0, 127);
        pixel(3, pk(10, 10, 10, 10), pk(10, 10, 10, 10), -200, 4096, 1'b0, 63);
        pixel(1, pk(-50, 0, 0, 0), pk(1, 0, 0, 0), 0, 65536, 1'b1, 0);
        pixel(1, pk(-50, 0, 0, 0), pk(1, 0, 0, 0), 0, 65536, 1'b0, -50);
        pixel(1, pk(-125, -125, -125, -125), pk(2, 2, 2, 2), 0, 65536, 1'b0, -128);
        pixel(1, pk(1, 1, 1, 0), pk(1, 1, 1, 1), 0, 32768, 1'b0, 2);
        pixel(1, pk(-1, -1, -1, 0), pk(1, 1, 1, 1), 0, 32768, 1'b0, -1);
        pixel(1, pk(1, 0, 0, 0), pk(1, 1, 1, 1), 0, 32768, 1'b0, 1);
        drain();

        // backpressure: result held, no beat consumed, next beat taken one edge after handshake
        out_ready = 1'b0;
        pixel(1, pk(5, 5, 5, 5), pk(1, 1, 1, 1), 0, 65536, 1'b0, 20);
        begin
            int k = 0;
            while (!out_valid && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!out_valid) chk("bp_valid_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_last = 1'b1; data_in = pk(2, 2, 2, 2); weight_in = pk(3, 3, 3, 3);
        bias = 0; scale = 65536; relu_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_result_hold", int'(result), 20);
            chk("bp_in_ready_low", int'(in_ready), 0);
            chk("bp_valid_hold", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        q.push_back(24);
        @(posedge clk);
        #1;
        chk("post_hs_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("post_hs_beat_taken", int'(in_ready), 0);
        drain();

        // asynchronous reset mid-pixel discards the partial accumulation
        beat(pk(100, 100, 100, 100), pk(100, 100, 100, 100), 1'b0, 0, 65536, 1'b0);
        beat(pk(100, 100, 100, 100), pk(100, 100, 100, 100), 1'b0, 0, 65536, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midreset_result", int'(result), 0);
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        pixel(1, pk(1, 1, 1, 1), pk(2, 2, 2, 2), 0, 65536, 1'b0, 8);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("idle_out_valid", int'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
